// File: rtl/key_pad_pkg.sv
// Shared keypad definitions: emulator state set, key-code mapping and the
// default 1 ms tick length used by both the emulator and the scanner.
package key_pad_pkg;

  localparam int unsigned T1MS_DEFAULT = 50_000;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_DN,
    HOLD,
    BOUNCE_UP,
    GAP
  } kp_state_t;

  function automatic logic [1:0] key_row(input logic [3:0] k);
    return k[3:2];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] k);
    return k[1:0];
  endfunction

  // Passive matrix: only the latched key's row can be pulled low, and only
  // while its column is driven low and the contact is closed.
  function automatic logic [3:0] row_sense(input logic [3:0] k,
                                           input logic [3:0] col,
                                           input logic       closed);
    logic [3:0] r;
    r = '1;
    if (closed && !col[key_col(k)])
      r[key_row(k)] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/key_pad_emu_tick_1ms.sv
// Free-running 0..T1MS-1 counter; tick is high on the last count of each period.
module tick_1ms
  import key_pad_pkg::*;
#(
  parameter int unsigned T1MS = T1MS_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned   CW   = (T1MS > 1) ? $clog2(T1MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(T1MS - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (count == LAST)
      count <= '0;
    else
      count <= count + CW'(1);
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/key_pad_emu.sv
// 4x4 matrix-keypad emulator: answers the scanner's active-low column drive
// with an active-low row for the requested key, with optional contact bounce.
module key_pad_emu
  import key_pad_pkg::*;
#(
  parameter int unsigned T1MS      = T1MS_DEFAULT,
  parameter int unsigned BOUNCE_MS = 4,
  parameter int unsigned GAP_MS    = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  key,
  input  logic [15:0] hold_ms,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic        busy,
  output logic        done,
  output logic        contact
);

  localparam bit         HAS_BOUNCE = (BOUNCE_MS != 0);
  localparam bit         HAS_GAP    = (GAP_MS != 0);
  localparam logic [7:0] B_LAST     = HAS_BOUNCE ? 8'(BOUNCE_MS - 1) : 8'd0;
  localparam logic [7:0] G_LAST     = HAS_GAP    ? 8'(GAP_MS - 1)    : 8'd0;

  kp_state_t   state_q, state_d;
  logic        contact_q, contact_d;
  logic [3:0]  key_q, key_d;
  logic [15:0] hold_q, hold_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic [7:0]  gcnt_q, gcnt_d;
  logic        done_q, done_d;
  logic        tick;

  tick_1ms #(
    .T1MS(T1MS)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      contact_q <= 1'b0;
      key_q     <= '0;
      hold_q    <= 16'd1;
      bcnt_q    <= '0;
      hcnt_q    <= '0;
      gcnt_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      contact_q <= contact_d;
      key_q     <= key_d;
      hold_q    <= hold_d;
      bcnt_q    <= bcnt_d;
      hcnt_q    <= hcnt_d;
      gcnt_q    <= gcnt_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    contact_d = contact_q;
    key_d     = key_q;
    hold_d    = hold_q;
    bcnt_d    = bcnt_q;
    hcnt_d    = hcnt_q;
    gcnt_d    = gcnt_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d     = key;
          hold_d    = (hold_ms == '0) ? 16'd1 : hold_ms;
          contact_d = 1'b1;
          if (HAS_BOUNCE) begin
            state_d = BOUNCE_DN;
            bcnt_d  = '0;
          end else begin
            state_d = HOLD;
            hcnt_d  = '0;
          end
        end
      end

      BOUNCE_DN: begin
        if (tick) begin
          if (bcnt_q == B_LAST) begin
            contact_d = 1'b1;
            state_d   = HOLD;
            hcnt_d    = '0;
          end else begin
            contact_d = ~contact_q;
            bcnt_d    = bcnt_q + 8'd1;
          end
        end
      end

      HOLD: begin
        contact_d = 1'b1;
        if (tick) begin
          if (hcnt_q == hold_q - 16'd1) begin
            contact_d = 1'b0;
            if (HAS_BOUNCE) begin
              state_d = BOUNCE_UP;
              bcnt_d  = '0;
            end else begin
              state_d = GAP;
              gcnt_d  = '0;
            end
          end else begin
            hcnt_d = hcnt_q + 16'd1;
          end
        end
      end

      BOUNCE_UP: begin
        if (tick) begin
          if (bcnt_q == B_LAST) begin
            contact_d = 1'b0;
            state_d   = GAP;
            gcnt_d    = '0;
          end else begin
            contact_d = ~contact_q;
            bcnt_d    = bcnt_q + 8'd1;
          end
        end
      end

      GAP: begin
        contact_d = 1'b0;
        // done is registered so it lands on the first IDLE cycle with busy low
        if (!HAS_GAP || (tick && gcnt_q == G_LAST)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (tick) begin
          gcnt_d = gcnt_q + 8'd1;
        end
      end

      default: begin
        state_d   = IDLE;
        contact_d = 1'b0;
      end
    endcase
  end

  assign row     = row_sense(key_q, col, contact_q);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign contact = contact_q;

endmodule

// File: tb/tb_key_pad_emu.sv
// Self-checking bench for key_pad_emu: table-driven key mapping, hand-written
// handshake/reset sequences and random traffic against a contact-sequence model.
module tb_key_pad_emu;

  localparam int unsigned T1MS      = 10;
  localparam int unsigned BOUNCE_MS = 4;
  localparam int unsigned GAP_MS    = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  key;
  logic [15:0] hold_ms;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        busy;
  logic        done;
  logic        contact;

  int n_assert = 0;
  int n_fail   = 0;

  key_pad_emu #(
    .T1MS     (T1MS),
    .BOUNCE_MS(BOUNCE_MS),
    .GAP_MS   (GAP_MS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .key    (key),
    .hold_ms(hold_ms),
    .col    (col),
    .row    (row),
    .busy   (busy),
    .done   (done),
    .contact(contact)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted press is a list of contact levels, one per
  // 1 ms interval; each tick consumes one entry, and the list running out is done.
  int unsigned m_cnt;
  bit          m_tick;
  logic        q_exp[$];
  logic [3:0]  m_key;
  logic        m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_key  = '0;
      q_exp.delete();
    end else begin
      m_tick = (m_cnt == T1MS - 1);
      m_cnt  = m_tick ? 0 : m_cnt + 1;
      m_done = 1'b0;
      if (q_exp.size() == 0) begin
        if (start) begin
          int unsigned h;
          h     = (hold_ms == 0) ? 1 : int'(hold_ms);
          m_key = key;
          for (int unsigned i = 0; i < BOUNCE_MS; i++) q_exp.push_back(i % 2 == 0);
          for (int unsigned i = 0; i < h; i++)         q_exp.push_back(1'b1);
          for (int unsigned i = 0; i < BOUNCE_MS; i++) q_exp.push_back(i % 2 == 1);
          for (int unsigned i = 0; i < GAP_MS; i++)    q_exp.push_back(1'b0);
        end
      end else if (m_tick) begin
        void'(q_exp.pop_front());
        if (q_exp.size() == 0) m_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic       exp_c;
    logic [3:0] exp_row;
    exp_c   = (q_exp.size() != 0) ? q_exp[0] : 1'b0;
    exp_row = 4'hF;
    if (exp_c && !col[m_key[1:0]]) exp_row[m_key[3:2]] = 1'b0;
    check("model_contact", contact, exp_c);
    check("model_busy", busy, q_exp.size() != 0);
    check("model_done", done, m_done);
    check("model_row", row, exp_row);
  end

  typedef struct {
    logic [3:0] key;
    logic [3:0] col;
    logic [3:0] row;
  } vec_t;

  vec_t vecs[48];

  task automatic start_op(input logic [3:0] k, input logic [15:0] h);
    @(posedge clk);
    #1;
    key     = k;
    hold_ms = h;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1'b1);
    check("busy_on_done", busy, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    key     = '0;
    hold_ms = '0;
    col     = 4'h0;

    for (int k = 0; k < 16; k++) begin
      logic [3:0] kk;
      logic [1:0] other;
      kk    = 4'(k);
      other = kk[1:0] + 2'd1;
      vecs[3*k]   = '{kk, ~(4'b0001 << kk[1:0]), ~(4'b0001 << kk[3:2])};
      vecs[3*k+1] = '{kk, ~(4'b0001 << other),   4'hF};
      vecs[3*k+2] = '{kk, 4'b0000,               ~(4'b0001 << kk[3:2])};
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset_row", row, 4'hF);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_contact", contact, 1'b0);
    col   = 4'hF;
    rst_n = 1'b1;

    // Key mapping, sampled well inside HOLD
    for (int k = 0; k < 16; k++) begin
      start_op(vecs[3*k].key, 16'd5);
      repeat (45) @(posedge clk);
      for (int j = 0; j < 3; j++) begin
        @(posedge clk);
        #1;
        col = vecs[3*k+j].col;
        #2;
        check("map_row", row, vecs[3*k+j].row);
        check("map_contact", contact, 1'b1);
      end
      @(posedge clk);
      #1;
      col = 4'hF;
      wait_done(400);
    end

    // Bounce shape and ignored start while busy
    col = 4'h0;
    start_op(4'h6, 16'd3);
    repeat (45) @(posedge clk);
    start_op(4'hF, 16'd2);
    #2;
    check("ignored_start_row", row, 4'b1101);
    wait_done(400);

    // hold_ms = 0 behaves as one tick
    start_op(4'h9, 16'd0);
    wait_done(400);

    // Asynchronous reset in HOLD
    start_op(4'h5, 16'd4);
    repeat (45) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_row", row, 4'hF);
    check("async_rst_contact", contact, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_op(4'h5, 16'd1);
    wait_done(400);

    // Random traffic, including starts while busy
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      col     = 4'($urandom);
      key     = 4'($urandom);
      hold_ms = 16'($urandom_range(0, 3));
      start   = ($urandom_range(0, 19) == 0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    begin
      bit idle = 1'b0;
      for (int i = 0; i < 400 && !idle; i++) begin
        @(negedge clk);
        if (!busy) idle = 1'b1;
      end
      check("final_idle", idle, 1'b1);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/key_pad_emu.md
Name: key_pad_emu

Overview:
- Synthesizable 4x4 matrix-keypad emulator: the responder end of the column-drive/row-sense keypad interface.
- Watches the scanner's active-low column drives and pulls the matching active-low row line low while an emulated key is "pressed".
- Press and release edges include optional contact bounce.
- Used for on-board self-test and bench stimulus of the keypad scanner, with no physical keypad attached.

Parameters:
- T1MS, 50_000, clock cycles per 1 ms tick (50 MHz clock); set small (e.g. 10) in simulation.
- BOUNCE_MS, 4, number of 1 ms ticks of contact chatter on each press and release edge; 0 disables bounce.
- GAP_MS, 30, minimum released time in 1 ms ticks after a release before done is asserted.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- key  in  4  key code to press; row index = key[3:2], column index = key[1:0]
- hold_ms  in  16  stable-press duration in 1 ms ticks; 0 is treated as 1
- col  in  4  column drive from scanner, active low
- row  out  4  row sense to scanner, active low, idle 4'b1111
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at the end of the GAP state
- contact  out  1  emulated switch contact, 1 = closed (debug)

Behaviour:
- Tick counter: free-running 0..T1MS-1, resets to 0. tick = (count == T1MS-1). Phase is not aligned to start, so the first tick interval of each state is at most 1 ms.
- Row output is combinational from col, like a passive matrix: row = 4'b1111, except row[key_q[3:2]] = 0 when contact=1 and col[key_q[1:0]]=0. Several columns driven low simultaneously still only affects the latched key's row.
- Reset values: state=IDLE, contact=0, key_q=0, hold_q=1, counters=0, done=0, busy=0, row=4'b1111 for any col.
- Reset mid-operation aborts immediately. contact=0 and row=1111 asynchronously; no done is issued.
- IDLE: on start=1, latch key_q<=key and hold_q<=max(hold_ms,1), and set contact<=1.
  - Next state is BOUNCE_DN (bcnt=0), or HOLD (hcnt=0) when BOUNCE_MS=0.
  - start while busy is ignored; the request is not queued.
- BOUNCE_DN: on each tick, if bcnt==BOUNCE_MS-1 then contact<=1 and go to HOLD (hcnt=0); else contact<=~contact and bcnt++.
- HOLD: contact stays 1. On each tick, if hcnt==hold_q-1 then contact<=0 and go to BOUNCE_UP (bcnt=0), or GAP (gcnt=0) when BOUNCE_MS=0; else hcnt++.
- BOUNCE_UP: on each tick, if bcnt==BOUNCE_MS-1 then contact<=0 and go to GAP (gcnt=0); else contact<=~contact and bcnt++.
- GAP: contact=0. On each tick, if gcnt==GAP_MS-1 (or immediately when GAP_MS=0) go to IDLE with done<=1 for exactly one cycle.
- Counter widths: bcnt and gcnt are 8 bits, hcnt is 16 bits. No wrap is possible within legal parameters (BOUNCE_MS, GAP_MS <= 255).
- Simultaneous start and done cycle: done is asserted while the state returns to IDLE, so start is accepted at the earliest on the following cycle.

Decomposition:
- Shared package key_pad_pkg holds:
  - state encoding constants (IDLE, BOUNCE_DN, HOLD, BOUNCE_UP, GAP);
  - the key-code-to-row/column mapping (key[3:2] → row bit, key[1:0] → col bit);
  - the default T1MS, which the scanner shares.
- One natural sub-module: tick_1ms, the free-running T1MS counter producing the tick pulse. It is reusable by the scanner.

Test Plan:
- Static mapping (T1MS=10, BOUNCE_MS=0): for each key 0..15, start with hold_ms=5 and drive col with a single low bit on column key[1:0]. During HOLD, row has exactly bit key[3:2] low; any other single-low col gives row=1111.
- Bounce shape (BOUNCE_MS=4, key=4'h6, hold_ms=3, col=0000): contact sequence per tick is 1,0,1,0 → 1 for 3 ticks → 0,1,0,1 → 0. row toggles 1101/1111 in step with contact.
- Handshake: start accepted, busy=1 next cycle. A second start with key=4'hF during HOLD is ignored, and key_q stays 6. done pulses for exactly 1 cycle after GAP_MS ticks, and busy=0 on the same cycle.
- hold_ms=0: behaves exactly as hold_ms=1, i.e. one HOLD tick.
- Async reset during HOLD with col=0000: row=1111 without waiting for a clock, no done pulse, and a new start after reset is accepted.
- Closed loop with the keypad scanner (T1MS=10, NUM_KEY=20, BOUNCE_MS=4, hold_ms=40, GAP_MS=30): each of keys 0..F yields one scanner flag pulse with data equal to the key code. With hold_ms=10 (shorter than debounce), no flag is produced.
